// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned IMEM_DEPTH_DEFAULT = 64;
  localparam logic [31:0] ZERO_INSTR = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Unsigned range check; the PC never wraps back into the legal window.
  function automatic logic pc_in_range(input logic [31:0] pc, input logic [31:0] depth);
    return pc < depth;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush beats push, head is read from storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(QDEPTH);

  fetch_entry_t  store [QDEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign head    = store[rd_ptr];
  // A push into a full queue is only legal when the head leaves at the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, fills a fetch queue, handles redirects.
// Optional build macro HALT_ON_ZERO_INSTR_EN stops fetch on an all-zero memory word.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned QDEPTH     = 2,
  parameter int unsigned BOOT_WAIT  = 1
) (
  input  logic         clk,
  input  logic         reset,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_rdata,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         halted,
  output logic         addr_err,
  output fetch_state_e state
);

  // Handshake: a head entry transfers on any rising edge where if_valid && if_ready;
  // if_valid never depends on if_ready, and a redirect flushes after that transfer.

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);
  localparam logic [31:0] BOOT_W  = 32'(BOOT_WAIT);

  logic [31:0]  pc;
  logic [31:0]  boot_cnt;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_head;
  fetch_entry_t q_din;
  logic         pop;
  logic         push;
  logic         flush;
  logic         redirect_take;
  logic         pc_ok;
  logic         redirect_ok;
  logic         slot_free;
  logic         zero_word;

  assign pc_ok         = pc_in_range(pc, DEPTH_W);
  assign redirect_ok   = pc_in_range(redirect_pc, DEPTH_W);
  assign pop           = !q_empty && if_ready;
  assign redirect_take = redirect_valid && (state != BOOT);
  assign flush         = redirect_take;
  assign slot_free     = !q_full || pop;

`ifdef HALT_ON_ZERO_INSTR_EN
  assign zero_word = (imem_rdata == ZERO_INSTR);
`else
  assign zero_word = 1'b0;
`endif

  assign push  = (state == RUN) && !redirect_take && pc_ok && slot_free && !zero_word;
  assign q_din = '{pc: pc, instr: imem_rdata};

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      boot_cnt <= '0;
      pc       <= RESET_PC;
      halted   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (boot_cnt + 32'd1 >= BOOT_W) begin
            state <= RUN;
          end else begin
            boot_cnt <= boot_cnt + 32'd1;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (!redirect_ok) begin
              state    <= HALT;
              halted   <= 1'b1;
              addr_err <= 1'b1;
            end
          end else if (!pc_ok) begin
            state    <= HALT;
            halted   <= 1'b1;
            addr_err <= 1'b1;
          end else if (zero_word && slot_free) begin
            // Unused memory reached: stop without consuming the PC.
            state  <= HALT;
            halted <= 1'b1;
          end else if (push) begin
            pc <= pc + 32'd1;
          end
        end
        HALT: begin
          // Only reset leaves HALT; a redirect still retargets the PC and flushes.
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign imem_addr = pc;
  assign if_valid  = !q_empty;
  assign if_instr  = q_head.instr;
  assign if_pc     = q_head.pc;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller; define HALT_ON_ZERO_INSTR_EN to cover the zero-word halt.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         if_valid;
  logic         if_ready = 1'b0;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'd0;
  logic         halted;
  logic         addr_err;
  fetch_state_e state;

  logic [31:0] imem [64];
  logic [63:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

`ifdef HALT_ON_ZERO_INSTR_EN
  localparam int unsigned LAST_PC   = 15;
  localparam logic [31:0] STOP_ADDR = 32'd16;
  localparam logic        STOP_AERR = 1'b0;
`else
  localparam int unsigned LAST_PC   = 63;
  localparam logic [31:0] STOP_ADDR = 32'd64;
  localparam logic        STOP_AERR = 1'b1;
`endif

  fetch_controller #(
    .IMEM_DEPTH (64),
    .RESET_PC   (32'd0),
    .QDEPTH     (2),
    .BOOT_WAIT  (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .addr_err       (addr_err),
    .state          (state)
  );

  // Clock and combinational instruction memory
  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32'd64) ? imem[imem_addr[5:0]] : 32'h0;

  initial begin
    for (int i = 0; i < 64; i++) begin
`ifdef HALT_ON_ZERO_INSTR_EN
      imem[i] = (i < 16) ? (32'h1000_0001 + 32'(i) * 32'h0101) : 32'h0;
`else
      imem[i] = 32'h1000_0001 + 32'(i) * 32'h0101;
`endif
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned first, input int unsigned last);
    for (int unsigned p = first; p <= last; p++) begin
      exp_q.push_back({p[31:0], imem[p[5:0]]});
    end
  endtask

  // Scoreboard: every completed handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_without_expectation", 64'(exp_q.size()), 64'd1);
      end else begin
        check("popped_entry", {if_pc, if_instr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic found;

    // Reset state
    tick();
    tick();
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", 64'(if_pc), 64'd0);
    check("rst_if_instr", 64'(if_instr), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    check("rst_state", 64'(state), 64'(BOOT));

    // Boot latency and backpressure
    push_exp(0, 4);
    reset = 1'b0;
    tick();
    check("e1_if_valid", 64'(if_valid), 64'd0);
    check("e1_imem_addr", 64'(imem_addr), 64'd0);
    tick();
    check("first_valid", 64'(if_valid), 64'd1);
    check("first_pc", 64'(if_pc), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("stall_if_valid", 64'(if_valid), 64'd1);
    check("stall_head_pc", 64'(if_pc), 64'd0);
    check("stall_imem_addr", 64'(imem_addr), 64'd2);
    if_ready = 1'b1;

    // Redirect while head is PC 4: PC 4 consumed, PC 5 flushed
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (if_valid && if_pc == 32'd4) found = 1'b1;
    end
    check("head_pc4_found", 64'(found), 64'd1);
    push_exp(LAST_PC < 15 ? LAST_PC : 15, LAST_PC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd15;
    tick();
    redirect_valid = 1'b0;
    check("redir_if_valid", 64'(if_valid), 64'd0);
    check("redir_imem_addr", 64'(imem_addr), 64'd15);
    tick();
    check("redir_valid_2cyc", 64'(if_valid), 64'd1);
    check("redir_head_pc", 64'(if_pc), 64'd15);

    // Run to the end of memory
    for (int i = 0; i < 200 && !halted; i++) tick();
    check("run_halted", 64'(halted), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    check("run_addr_err", 64'(addr_err), 64'(STOP_AERR));
    check("run_state", 64'(state), 64'(HALT));
    check("run_stop_addr", 64'(imem_addr), 64'(STOP_ADDR));
    check("run_drained", 64'(exp_q.size()), 64'd0);
    check("run_if_valid", 64'(if_valid), 64'd0);

    // Out-of-range redirect in RUN halts at once
    if_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_redir_full", 64'(if_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd70;
    tick();
    redirect_valid = 1'b0;
    check("bad_redir_halted", 64'(halted), 64'd1);
    check("bad_redir_addr_err", 64'(addr_err), 64'd1);
    check("bad_redir_flushed", 64'(if_valid), 64'd0);
    check("bad_redir_addr", 64'(imem_addr), 64'd70);
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("bad_redir_no_fetch", 64'(imem_addr), 64'd70);
    check("bad_redir_state", 64'(state), 64'(HALT));

    // Reset with a full queue in RUN, then restart with random backpressure
    if_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("full_state_run", 64'(state), 64'(RUN));
    check("full_if_valid", 64'(if_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_if_valid", 64'(if_valid), 64'd0);
    check("mid_rst_imem_addr", 64'(imem_addr), 64'd0);
    check("mid_rst_halted", 64'(halted), 64'd0);
    check("mid_rst_state", 64'(state), 64'(BOOT));
    push_exp(0, LAST_PC);
    reset = 1'b0;
    for (int i = 0; i < 600 && !halted; i++) begin
      if_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("restart_halted", 64'(halted), 64'd1);
    if_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("restart_drained", 64'(exp_q.size()), 64'd0);
    check("restart_stop_addr", 64'(imem_addr), 64'(STOP_ADDR));
    check("restart_addr_err", 64'(addr_err), 64'(STOP_AERR));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
